instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage: fetches one word per cycle from IMEM into the IF/ID register, with redirect and hold support.
// Latency 1 cycle; STALL freezes PC and IF/ID, BUSYWAIT inserts bubbles, BRANCH_TAKEN overrides both.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;
    logic [31:0] ifid_instr, ifid_instr_nxt;
    logic [31:0] ifid_pc, ifid_pc_nxt;
    logic [31:0] ifid_pc4, ifid_pc4_nxt;
    logic        ifid_vld, ifid_vld_nxt;
    logic [31:0] pc_plus4;

    // Redirect targets are word aligned; the low bits are deliberately ignored.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^BRANCH_TARGET[1:0];

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= FETCH;
            pc         <= RESET_PC_ALIGNED;
            buf_instr  <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            buf_instr  <= buf_instr_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_pc4   <= ifid_pc4_nxt;
            ifid_vld   <= ifid_vld_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        buf_instr_nxt  = buf_instr;
        ifid_instr_nxt = ifid_instr;
        ifid_pc_nxt    = ifid_pc;
        ifid_pc4_nxt   = ifid_pc4;
        ifid_vld_nxt   = ifid_vld;
        IMEM_READ      = (state == FETCH);

        if (BRANCH_TAKEN) begin
            // Any word returning this cycle belongs to the wrong path and is dropped.
            pc_nxt         = {BRANCH_TARGET[31:2], 2'b00};
            ifid_instr_nxt = NOP_INSTR;
            ifid_vld_nxt   = 1'b0;
            buf_instr_nxt  = 32'h0;
            state_nxt      = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (IMEM_BUSYWAIT) begin
                        if (!STALL) begin
                            ifid_instr_nxt = NOP_INSTR;
                            ifid_vld_nxt   = 1'b0;
                        end
                    end else if (!STALL) begin
                        ifid_instr_nxt = IMEM_READDATA;
                        ifid_pc_nxt    = pc;
                        ifid_pc4_nxt   = pc_plus4;
                        ifid_vld_nxt   = 1'b1;
                        pc_nxt         = pc_plus4;
                    end else begin
                        // PC is frozen while holding, so it still tags the buffered word.
                        buf_instr_nxt = IMEM_READDATA;
                        state_nxt     = HOLD;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        ifid_instr_nxt = buf_instr;
                        ifid_pc_nxt    = pc;
                        ifid_pc4_nxt   = pc_plus4;
                        ifid_vld_nxt   = 1'b1;
                        pc_nxt         = pc_plus4;
                        state_nxt      = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    assign IMEM_ADDRESS = pc;
    assign INSTRUCTION  = ifid_instr;
    assign PC_OUT       = ifid_pc;
    assign PC_PLUS4     = ifid_pc4;
    assign VALID        = ifid_vld;

endmodule
